axis_adder: RTL and testbench



---
 rtl/axis_adder_pkg.sv | 23 ++
 rtl/axis_adder.sv | 142 ++++++++++++++
 tb/tb_axis_adder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_adder_pkg.sv
// ---------------------------------------------------------------------------
// axis_adder_pkg
//
// Purpose:
//   Shared stream parameters for the mesh endpoints. The compute endpoint and
//   the number-generator peers all agree on these widths, so they live here
//   rather than in each module.
//
// Contents:
//   AXIS_TDATAW  - AXI-Stream data width (operands and results)
//   AXIS_TDESTW  - AXI-Stream TDEST width (mesh routing ID width)
//   AXIS_TIDW    - AXI-Stream TID width (reserved, no TID ports yet)
//   NODE_ID_0_0  - routing ID of mesh node (0,0)
// ---------------------------------------------------------------------------
package axis_adder_pkg;

    localparam int AXIS_TDATAW = 32;
    localparam int AXIS_TDESTW = 4;
    localparam int AXIS_TIDW   = 2;

    localparam logic [AXIS_TDESTW-1:0] NODE_ID_0_0 = '0;

endpackage : axis_adder_pkg

// File: rtl/axis_adder.sv
// ---------------------------------------------------------------------------
// axis_adder
//
// Purpose:
//   AXI-Stream compute endpoint on one mesh node. Single-word operands arrive
//   on the slave stream and are paired in arrival order (first word A, second
//   word B). The sum A+B (carry dropped) leaves as a single-beat packet on
//   the master stream, addressed to a fixed destination node.
//
// Ports:
//   CLK            in   single clock, rising-edge
//   RST            in   synchronous reset, active-high
//   AXIS_S_TVALID  in   operand beat valid
//   AXIS_S_TREADY  out  block can accept an operand
//   AXIS_S_TDATA   in   operand value, unsigned
//   AXIS_S_TLAST   in   packet end (ignored for pairing)
//   AXIS_S_TDEST   in   arriving destination (ignored)
//   AXIS_M_TVALID  out  result beat valid
//   AXIS_M_TREADY  in   downstream accepts result
//   AXIS_M_TDATA   out  sum
//   AXIS_M_TLAST   out  1 whenever a result is presented
//   AXIS_M_TDEST   out  constant RESULT_DEST
// ---------------------------------------------------------------------------
module axis_adder
    import axis_adder_pkg::*;
#(
    parameter int                TDATAW      = AXIS_TDATAW,
    parameter int                TDESTW      = AXIS_TDESTW,
    parameter int                TIDW        = AXIS_TIDW,
    parameter logic [TDESTW-1:0] RESULT_DEST = NODE_ID_0_0
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,

    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SEND   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TDATAW-1:0] regA_q,  regA_d;
    logic [TDATAW-1:0] mData_q, mData_d;
    logic              mValid_q, mValid_d;
    logic              mLast_q,  mLast_d;

    logic              sReady;
    logic              sHandshake;
    logic              mHandshake;

    // TLAST/TDEST of arriving beats carry no meaning here: every accepted
    // beat is one operand. TID is reserved for a later revision. These sinks
    // keep the unused inputs visibly intentional.
    logic              unusedInputs;
    logic [TIDW-1:0]   unusedTid;

    assign unusedInputs = ^{AXIS_S_TLAST, AXIS_S_TDEST};
    assign unusedTid    = '0;

    // Ready depends on state only (never on TVALID), so upstream can't form a
    // combinational loop through us. It is held low while RST is asserted so
    // nothing is offered acceptance during reset.
    assign sReady     = (state_q != SEND) && !RST;
    assign sHandshake = AXIS_S_TVALID && sReady;
    assign mHandshake = mValid_q && AXIS_M_TREADY;

    // Next-state logic: capture A, then form the sum when B arrives and hold
    // the result (data/last stable) until the downstream takes it.
    always_comb begin
        state_d  = state_q;
        regA_d   = regA_q;
        mData_d  = mData_q;
        mValid_d = mValid_q;
        mLast_d  = mLast_q;

        unique case (state_q)
            WAIT_A: begin
                if (sHandshake) begin
                    regA_d  = AXIS_S_TDATA;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (sHandshake) begin
                    // Same-width add: the carry out is dropped (mod 2^TDATAW).
                    mData_d  = regA_q + AXIS_S_TDATA;
                    mValid_d = 1'b1;
                    mLast_d  = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (mHandshake) begin
                    mValid_d = 1'b0;
                    mLast_d  = 1'b0;
                    state_d  = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // State and datapath registers. Reset discards a half-formed pair and any
    // result the downstream has not yet accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= WAIT_A;
            regA_q   <= '0;
            mData_q  <= '0;
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            regA_q   <= regA_d;
            mData_q  <= mData_d;
            mValid_q <= mValid_d;
            mLast_q  <= mLast_d;
        end
    end

    assign AXIS_S_TREADY = sReady;
    assign AXIS_M_TVALID = mValid_q;
    assign AXIS_M_TDATA  = mData_q;
    assign AXIS_M_TLAST  = mLast_q;
    assign AXIS_M_TDEST  = RESULT_DEST;

endmodule : axis_adder

// File: tb/tb_axis_adder.sv
// ---------------------------------------------------------------------------
// tb_axis_adder
//
// Purpose:
//   Self-checking bench for axis_adder. The reference model pairs accepted
//   operands in arrival order and queues their 32-bit sum; a monitor pops
//   that queue whenever a result beat is transferred. Directed phases cover
//   reset, latency, wrap-around, back-pressure, back-to-back streaming and
//   mid-operation reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_axis_adder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        sValid = 1'b0;
    logic        sReady;
    logic [31:0] sData  = '0;
    logic        sLast  = 1'b0;
    logic [3:0]  sDest  = '0;

    logic        mValid;
    logic        mReady;
    logic [31:0] mData;
    logic        mLast;
    logic [3:0]  mDest;

    logic        mReadyDirect = 1'b1;
    logic        mReadyRand   = 1'b1;
    logic        randReadyEn  = 1'b0;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] opQ[$];
    logic [31:0] expQ[$];

    logic        prevStall = 1'b0;
    logic [31:0] prevData  = '0;

    assign mReady = randReadyEn ? mReadyRand : mReadyDirect;

    axis_adder dut (
        .CLK           (CLK),
        .RST           (RST),
        .AXIS_S_TVALID (sValid),
        .AXIS_S_TREADY (sReady),
        .AXIS_S_TDATA  (sData),
        .AXIS_S_TLAST  (sLast),
        .AXIS_S_TDEST  (sDest),
        .AXIS_M_TVALID (mValid),
        .AXIS_M_TREADY (mReady),
        .AXIS_M_TDATA  (mData),
        .AXIS_M_TLAST  (mLast),
        .AXIS_M_TDEST  (mDest)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Random downstream readiness, used only in the random phase.
    always @(posedge CLK) begin
        #1;
        mReadyRand = 1'($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Reference model and monitor. Sampling on the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge CLK) begin
        logic [31:0] sum;
        logic [31:0] exp;
        if (RST) begin
            opQ.delete();
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkBit("stall_valid", mValid, 1'b1);
                checkOutput("stall_data", mData, prevData);
                checkBit("stall_last", mLast, 1'b1);
            end
            if (sValid && sReady) begin
                opQ.push_back(sData);
                if (opQ.size() == 2) begin
                    sum = opQ[0] + opQ[1];
                    expQ.push_back(sum);
                    opQ.delete();
                end
            end
            if (mValid && mReady) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%08h, expected no beat", mData);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("result_data", mData, exp);
                    checkBit("result_last", mLast, 1'b1);
                    checkOutput("result_dest", 32'(mDest), 32'd0);
                end
            end
            prevStall = mValid && !mReady;
            prevData  = mData;
        end
    end

    // Offer one operand and wait until it is taken. Valid stays high on
    // return so back-to-back offers keep the stream continuous.
    task automatic applyStimulus(input logic [31:0] data, output int waits);
        sData  = data;
        sValid = 1'b1;
        sLast  = 1'($urandom);
        sDest  = 4'($urandom);
        waits  = 0;
        forever begin
            @(negedge CLK);
            if (sReady) break;
            waits++;
            if (waits > 200) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL operand_timeout: got no S_TREADY, expected acceptance of 0x%08h", data);
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic dropValid();
        sValid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || mValid) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        checkBit({name, "_drained"}, (expQ.size() == 0 && !mValid), 1'b1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int w;
        logic [31:0] a;
        logic [31:0] b;

        $display("[TB] starting axis_adder bench");

        // Reset and idle.
        repeat (5) begin
            @(posedge CLK);
            @(negedge CLK);
            checkBit("reset_mvalid", mValid, 1'b0);
            checkOutput("reset_mdest", 32'(mDest), 32'd0);
            checkBit("reset_sready", sReady, 1'b0);
            checkOutput("reset_mdata", mData, 32'd0);
            checkBit("reset_mlast", mLast, 1'b0);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkBit("release_sready", sReady, 1'b1);
        checkBit("release_mvalid", mValid, 1'b0);
        @(posedge CLK);
        #1;

        // Basic add with one-cycle latency and ready recovery after the send.
        mReadyDirect = 1'b1;
        applyStimulus(32'h0000_0005, w);
        applyStimulus(32'h0000_0007, w);
        dropValid();
        @(negedge CLK);
        checkBit("latency_mvalid", mValid, 1'b1);
        checkOutput("basic_data", mData, 32'h0000_000C);
        checkBit("send_sready", sReady, 1'b0);
        @(negedge CLK);
        checkBit("after_send_mvalid", mValid, 1'b0);
        checkBit("after_send_sready", sReady, 1'b1);
        waitIdle("basic");

        // Wrap-around.
        applyStimulus(32'hFFFF_FFFF, w);
        applyStimulus(32'h0000_0002, w);
        dropValid();
        @(negedge CLK);
        checkOutput("wrap_data", mData, 32'h0000_0001);
        waitIdle("wrap");

        // Back-pressure: result held and input blocked for the whole stall.
        mReadyDirect = 1'b0;
        applyStimulus(32'h0000_0010, w);
        applyStimulus(32'h0000_0020, w);
        dropValid();
        repeat (6) begin
            @(negedge CLK);
            checkBit("bp_mvalid", mValid, 1'b1);
            checkOutput("bp_data", mData, 32'h0000_0030);
            checkBit("bp_sready", sReady, 1'b0);
        end
        @(posedge CLK);
        #1 mReadyDirect = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checkBit("bp_released", mValid, 1'b0);
        waitIdle("bp");

        // Back-to-back stream 1,2,3,4: the third operand waits out SEND.
        applyStimulus(32'd1, w);
        applyStimulus(32'd2, w);
        applyStimulus(32'd3, w);
        checkOutput("stream_held_off", 32'(w), 32'd1);
        applyStimulus(32'd4, w);
        dropValid();
        waitIdle("stream");

        // Mid-operation reset loses the captured A.
        applyStimulus(32'h0000_0099, w);
        dropValid();
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        applyStimulus(32'd1, w);
        applyStimulus(32'd2, w);
        dropValid();
        @(negedge CLK);
        checkOutput("reset_midop_data", mData, 32'd3);
        waitIdle("midop");

        // Random operands, gaps and downstream stalls.
        randReadyEn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = (i % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = $urandom;
            applyStimulus(a, w);
            if ($urandom_range(0, 2) == 0) begin
                dropValid();
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
            applyStimulus(b, w);
            dropValid();
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
        randReadyEn  = 1'b0;
        mReadyDirect = 1'b1;
        waitIdle("random");
        checkOutput("pending_operands", 32'(opQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so a stuck handshake still reaches the summary.
    initial begin
        #500000;
        miscompares++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_axis_adder
